// File: rtl/uart_rx_deser_cfg_if.sv
// Bundle between the RX sampler/FSM side (master) and the configurable deserializer (slave).
// Carries per-frame configuration, sampled bits and the published word.
interface uart_rx_deser_cfg_if #(
   parameter int Data_Width     = 8,
   parameter int Prescale_Width = 6,
   parameter int Len_Width      = 4
);
   logic                      Sampled_Bit;
   logic                      Deser_En;
   logic [Prescale_Width-1:0] Prescale;
   logic [Prescale_Width-1:0] Edge_Cnt;
   logic [Len_Width-1:0]      Data_Len;
   logic                      Msb_First;
   logic                      Par_Type;
   logic [Data_Width-1:0]     P_Data;
   logic                      Data_Valid;
   logic                      Par_Bit;
   logic [Len_Width-1:0]      Bit_Cnt;
   logic                      Abort;

   modport master (
      output Sampled_Bit, Deser_En, Prescale, Edge_Cnt, Data_Len, Msb_First, Par_Type,
      input  P_Data, Data_Valid, Par_Bit, Bit_Cnt, Abort
   );

   modport slave (
      input  Sampled_Bit, Deser_En, Prescale, Edge_Cnt, Data_Len, Msb_First, Par_Type,
      output P_Data, Data_Valid, Par_Bit, Bit_Cnt, Abort
   );
endinterface

// File: rtl/uart_rx_deser_cfg.sv
// Configurable UART RX deserializer: captures bits at the mid-bit sample point and
// publishes a right-justified word plus expected parity when a frame completes.
module uart_rx_deser_cfg #(
   parameter int Data_Width     = 8,
   parameter int Prescale_Width = 6,
   parameter int Len_Width      = 4,
   parameter int Sample_Offset  = 3
) (
   input logic                clk,
   input logic                rst,
   uart_rx_deser_cfg_if.slave bus
);
   localparam int W = Data_Width;
   localparam logic [Len_Width-1:0] W_L  = Len_Width'(Data_Width);
   localparam logic [W-1:0]         ONES = '1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         sr_q, sr_d;
   logic                 acc_q, acc_d;
   logic [Len_Width-1:0] cnt_q, cnt_d;
   logic [Len_Width-1:0] len_q, len_d;
   logic                 msb_q, msb_d;
   logic                 par_type_q, par_type_d;
   logic [W-1:0]         p_data_q, p_data_d;
   logic                 par_bit_q, par_bit_d;
   logic                 valid_q, valid_d;
   logic                 abort_q, abort_d;

   logic [Prescale_Width:0] sample_pt;
   logic                    strobe;
   logic [Len_Width-1:0]    eff_len;
   logic                    from_idle;
   logic                    take;
   logic [Len_Width-1:0]    cfg_len;
   logic                    cfg_msb;
   logic                    cfg_par;
   logic [W-1:0]            sr_base;
   logic                    acc_base;
   logic [Len_Width-1:0]    cnt_base;
   logic [W-1:0]            sr_shift;
   logic                    acc_shift;
   logic                    last;
   logic [W-1:0]            aligned;

   // Sum is one bit wider so a large Prescale cannot wrap onto a small Edge_Cnt.
   assign sample_pt = ({1'b0, bus.Prescale} >> 1) + (Prescale_Width + 1)'(Sample_Offset);
   assign strobe    = ({1'b0, bus.Edge_Cnt} == sample_pt);
   assign eff_len   = ((bus.Data_Len == '0) || (bus.Data_Len > W_L)) ? W_L : bus.Data_Len;

   // A strobe in the starting cycle must see the configuration being latched, not the stale copy.
   assign from_idle = (state_q == IDLE);
   assign take      = strobe && bus.Deser_En && (state_q != DONE);
   assign cfg_len   = from_idle ? eff_len       : len_q;
   assign cfg_msb   = from_idle ? bus.Msb_First : msb_q;
   assign cfg_par   = from_idle ? bus.Par_Type  : par_type_q;
   assign sr_base   = from_idle ? '0            : sr_q;
   assign acc_base  = from_idle ? 1'b0          : acc_q;
   assign cnt_base  = from_idle ? '0            : cnt_q;

   assign sr_shift  = cfg_msb ? {sr_base[W-2:0], bus.Sampled_Bit}
                              : {bus.Sampled_Bit, sr_base[W-1:1]};
   assign acc_shift = acc_base ^ bus.Sampled_Bit;
   assign last      = (cnt_base == cfg_len - 1'b1);
   assign aligned   = cfg_msb ? (sr_shift & ~(ONES << cfg_len))
                              : (sr_shift >> (W_L - cfg_len));

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      msb_d      = msb_q;
      par_type_d = par_type_q;
      p_data_d   = p_data_q;
      par_bit_d  = par_bit_q;
      valid_d    = 1'b0;
      abort_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.Deser_En) begin
               len_d      = eff_len;
               msb_d      = bus.Msb_First;
               par_type_d = bus.Par_Type;
               sr_d       = '0;
               acc_d      = 1'b0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (!bus.Deser_En) begin
               abort_d = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         DONE: begin
            if (!bus.Deser_En) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         sr_d  = sr_shift;
         acc_d = acc_shift;
         cnt_d = cnt_base + 1'b1;
         if (last) begin
            p_data_d  = aligned;
            par_bit_d = acc_shift ^ cfg_par;
            valid_d   = 1'b1;
            state_d   = DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         acc_q      <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         msb_q      <= 1'b0;
         par_type_q <= 1'b0;
         p_data_q   <= '0;
         par_bit_q  <= 1'b0;
         valid_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         msb_q      <= msb_d;
         par_type_q <= par_type_d;
         p_data_q   <= p_data_d;
         par_bit_q  <= par_bit_d;
         valid_q    <= valid_d;
         abort_q    <= abort_d;
      end
   end

   assign bus.P_Data     = p_data_q;
   assign bus.Data_Valid = valid_q;
   assign bus.Par_Bit    = par_bit_q;
   assign bus.Bit_Cnt    = cnt_q;
   assign bus.Abort      = abort_q;
endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Directed bench for uart_rx_deser_cfg: each task drives one scenario and checks
// outputs on the falling edge against hand-computed values.
module tb_uart_rx_deser_cfg;
   logic clk;
   logic rst;
   int   compared;
   int   failed;
   int   valid_seen;
   int   abort_seen;
   int   valid_snap;
   logic [5:0] sp;

   uart_rx_deser_cfg_if #(.Data_Width(8), .Prescale_Width(6), .Len_Width(4)) bus ();

   uart_rx_deser_cfg #(
      .Data_Width(8), .Prescale_Width(6), .Len_Width(4), .Sample_Offset(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse counters sample the registered outputs before they update on each edge.
   always @(posedge clk) begin
      if (bus.Data_Valid) valid_seen++;
      if (bus.Abort)      abort_seen++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_bit(input logic b, input logic [5:0] ec);
      bus.Sampled_Bit = b;
      bus.Edge_Cnt    = ec;
      @(negedge clk);
      bus.Edge_Cnt    = '0;
      bus.Sampled_Bit = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int n, input logic msb);
      for (int i = 0; i < n; i++) send_bit(msb ? v[n-1-i] : v[i], sp);
   endtask

   task automatic start_frame(input logic [3:0] len, input logic msb, input logic par);
      bus.Data_Len  = len;
      bus.Msb_First = msb;
      bus.Par_Type  = par;
      bus.Deser_En  = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_frame();
      bus.Deser_En = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      compared++; if (bus.P_Data !== 8'h00) begin failed++; $display("[TB] FAIL reset_pdata: got %h want 00", bus.P_Data); end
      compared++; if (bus.Data_Valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %b want 0", bus.Data_Valid); end
      compared++; if (bus.Par_Bit !== 1'b0) begin failed++; $display("[TB] FAIL reset_par: got %b want 0", bus.Par_Bit); end
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus.Bit_Cnt); end
      compared++; if (bus.Abort !== 1'b0) begin failed++; $display("[TB] FAIL reset_abort: got %b want 0", bus.Abort); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lsb_frame();
      sp = 6'd7;
      bus.Prescale = 6'd8;
      start_frame(4'd8, 1'b0, 1'b0);
      send_byte(8'hA5, 8, 1'b0);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL lsb_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'hA5) begin failed++; $display("[TB] FAIL lsb_pdata: got %h want a5", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b0) begin failed++; $display("[TB] FAIL lsb_par: got %b want 0", bus.Par_Bit); end
      compared++; if (bus.Bit_Cnt !== 4'd8) begin failed++; $display("[TB] FAIL lsb_cnt: got %0d want 8", bus.Bit_Cnt); end
      @(negedge clk);
      compared++; if (bus.Data_Valid !== 1'b0) begin failed++; $display("[TB] FAIL lsb_valid_pulse: got %b want 0", bus.Data_Valid); end
      bus.Deser_En = 1'b0;
      @(negedge clk);
      compared++; if (bus.Abort !== 1'b0) begin failed++; $display("[TB] FAIL done_no_abort: got %b want 0", bus.Abort); end
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL done_idle_cnt: got %0d want 0", bus.Bit_Cnt); end
      @(negedge clk);
   endtask

   task automatic test_msb_frame();
      start_frame(4'd8, 1'b1, 1'b1);
      // Reconfigure after latching: must not affect this frame.
      bus.Data_Len  = 4'd3;
      bus.Msb_First = 1'b0;
      bus.Par_Type  = 1'b0;
      send_byte(8'hA5, 8, 1'b1);
      compared++; if (bus.P_Data !== 8'hA5) begin failed++; $display("[TB] FAIL msb_pdata: got %h want a5", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b1) begin failed++; $display("[TB] FAIL msb_par: got %b want 1", bus.Par_Bit); end
      compared++; if (bus.Bit_Cnt !== 4'd8) begin failed++; $display("[TB] FAIL msb_cnt: got %0d want 8", bus.Bit_Cnt); end
      end_frame();
      start_frame(4'd8, 1'b1, 1'b1);
      send_byte(8'hC0, 8, 1'b1);
      compared++; if (bus.P_Data !== 8'hC0) begin failed++; $display("[TB] FAIL msb_c0_pdata: got %h want c0", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b1) begin failed++; $display("[TB] FAIL msb_c0_par: got %b want 1", bus.Par_Bit); end
      end_frame();
   endtask

   task automatic test_short_len();
      valid_snap = valid_seen;
      start_frame(4'd5, 1'b0, 1'b0);
      send_byte(8'h0D, 5, 1'b0);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL len5_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'h0D) begin failed++; $display("[TB] FAIL len5_pdata: got %h want 0d", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b1) begin failed++; $display("[TB] FAIL len5_par: got %b want 1", bus.Par_Bit); end
      compared++; if (bus.Bit_Cnt !== 4'd5) begin failed++; $display("[TB] FAIL len5_cnt: got %0d want 5", bus.Bit_Cnt); end
      send_bit(1'b1, sp);
      send_bit(1'b1, sp);
      compared++; if (bus.Bit_Cnt !== 4'd5) begin failed++; $display("[TB] FAIL done_ignore_cnt: got %0d want 5", bus.Bit_Cnt); end
      compared++; if (bus.P_Data !== 8'h0D) begin failed++; $display("[TB] FAIL done_ignore_pdata: got %h want 0d", bus.P_Data); end
      end_frame();
      compared++; if (valid_seen !== valid_snap + 1) begin failed++; $display("[TB] FAIL len5_pulses: got %0d want %0d", valid_seen - valid_snap, 1); end
      start_frame(4'd1, 1'b0, 1'b0);
      send_bit(1'b1, sp);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL len1_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'h01) begin failed++; $display("[TB] FAIL len1_pdata: got %h want 01", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b1) begin failed++; $display("[TB] FAIL len1_par: got %b want 1", bus.Par_Bit); end
      compared++; if (bus.Bit_Cnt !== 4'd1) begin failed++; $display("[TB] FAIL len1_cnt: got %0d want 1", bus.Bit_Cnt); end
      end_frame();
   endtask

   task automatic test_len_clamp();
      start_frame(4'd0, 1'b0, 1'b0);
      send_byte(8'h96, 7, 1'b0);
      compared++; if (bus.Bit_Cnt !== 4'd7) begin failed++; $display("[TB] FAIL len0_cnt7: got %0d want 7", bus.Bit_Cnt); end
      compared++; if (bus.Data_Valid !== 1'b0) begin failed++; $display("[TB] FAIL len0_early_valid: got %b want 0", bus.Data_Valid); end
      send_bit(1'b1, sp);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL len0_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'h96) begin failed++; $display("[TB] FAIL len0_pdata: got %h want 96", bus.P_Data); end
      end_frame();
      start_frame(4'd12, 1'b1, 1'b0);
      send_byte(8'h3C, 8, 1'b1);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL len12_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'h3C) begin failed++; $display("[TB] FAIL len12_pdata: got %h want 3c", bus.P_Data); end
      compared++; if (bus.Bit_Cnt !== 4'd8) begin failed++; $display("[TB] FAIL len12_cnt: got %0d want 8", bus.Bit_Cnt); end
      end_frame();
   endtask

   task automatic test_prescale32();
      sp = 6'd19;
      bus.Prescale = 6'd32;
      bus.Deser_En = 1'b0;
      send_bit(1'b1, 6'd19);
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL p32_idle_strobe: got %0d want 0", bus.Bit_Cnt); end
      start_frame(4'd8, 1'b0, 1'b0);
      send_bit(1'b1, 6'd18);
      send_bit(1'b1, 6'd20);
      send_bit(1'b1, 6'd7);
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL p32_off_edge: got %0d want 0", bus.Bit_Cnt); end
      send_byte(8'h3C, 8, 1'b0);
      compared++; if (bus.P_Data !== 8'h3C) begin failed++; $display("[TB] FAIL p32_pdata: got %h want 3c", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b0) begin failed++; $display("[TB] FAIL p32_par: got %b want 0", bus.Par_Bit); end
      end_frame();
   endtask

   task automatic test_abort();
      valid_snap = valid_seen;
      start_frame(4'd8, 1'b0, 1'b0);
      send_byte(8'h07, 3, 1'b0);
      compared++; if (bus.Bit_Cnt !== 4'd3) begin failed++; $display("[TB] FAIL abort_cnt3: got %0d want 3", bus.Bit_Cnt); end
      bus.Deser_En = 1'b0;
      @(negedge clk);
      compared++; if (bus.Abort !== 1'b1) begin failed++; $display("[TB] FAIL abort_pulse: got %b want 1", bus.Abort); end
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL abort_cnt: got %0d want 0", bus.Bit_Cnt); end
      compared++; if (bus.P_Data !== 8'h3C) begin failed++; $display("[TB] FAIL abort_pdata: got %h want 3c", bus.P_Data); end
      @(negedge clk);
      compared++; if (bus.Abort !== 1'b0) begin failed++; $display("[TB] FAIL abort_one_cycle: got %b want 0", bus.Abort); end
      compared++; if (valid_seen !== valid_snap) begin failed++; $display("[TB] FAIL abort_no_valid: got %0d want 0", valid_seen - valid_snap); end
      compared++; if (abort_seen !== 1) begin failed++; $display("[TB] FAIL abort_total: got %0d want 1", abort_seen); end
   endtask

   task automatic test_reset_midframe();
      sp = 6'd7;
      bus.Prescale = 6'd8;
      start_frame(4'd8, 1'b0, 1'b0);
      send_byte(8'h0F, 4, 1'b0);
      rst = 1'b0;
      bus.Deser_En = 1'b0;
      #1;
      compared++; if (bus.P_Data !== 8'h00) begin failed++; $display("[TB] FAIL rstmid_pdata: got %h want 00", bus.P_Data); end
      compared++; if (bus.Bit_Cnt !== 4'd0) begin failed++; $display("[TB] FAIL rstmid_cnt: got %0d want 0", bus.Bit_Cnt); end
      compared++; if (bus.Par_Bit !== 1'b0) begin failed++; $display("[TB] FAIL rstmid_par: got %b want 0", bus.Par_Bit); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_frame(4'd8, 1'b0, 1'b0);
      send_byte(8'h5A, 8, 1'b0);
      compared++; if (bus.Data_Valid !== 1'b1) begin failed++; $display("[TB] FAIL post_rst_valid: got %b want 1", bus.Data_Valid); end
      compared++; if (bus.P_Data !== 8'h5A) begin failed++; $display("[TB] FAIL post_rst_pdata: got %h want 5a", bus.P_Data); end
      compared++; if (bus.Par_Bit !== 1'b0) begin failed++; $display("[TB] FAIL post_rst_par: got %b want 0", bus.Par_Bit); end
      end_frame();
   endtask

   initial begin
      compared        = 0;
      failed          = 0;
      valid_seen      = 0;
      abort_seen      = 0;
      valid_snap      = 0;
      sp              = 6'd7;
      rst             = 1'b0;
      bus.Sampled_Bit = 1'b0;
      bus.Deser_En    = 1'b0;
      bus.Prescale    = 6'd8;
      bus.Edge_Cnt    = '0;
      bus.Data_Len    = 4'd8;
      bus.Msb_First   = 1'b0;
      bus.Par_Type    = 1'b0;
      @(negedge clk);
      test_reset();
      test_lsb_frame();
      test_msb_frame();
      test_short_len();
      test_len_clamp();
      test_prescale32();
      test_abort();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
